register_file: RTL and testbench
================================

# register_file

Register file for the Simple RISC processor: 16 × 32-bit general-purpose registers, two registered read ports (A, B) and one synchronous write port, all gated by a stage enable. It sits in the decode/write-back path. Operands leave on BusA/BusB, and write-back data arrives on BusW. A debug view of every register is exported for benches and waveform inspection.

## Interface
- DATA_W, 32, register and bus width
- REG_COUNT, 16, number of registers
- ADDR_W, 4, register address width, equal to log2(REG_COUNT)

- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; clears all state
- RA  in  ADDR_W  read address, port A
- RB  in  ADDR_W  read address, port B
- RW  in  ADDR_W  write address
- EnW  in  1  write enable
- BusW  in  DATA_W  write data
- EN  in  1  stage enable; gates both reads and writes
- BusA  out  DATA_W  registered read data, port A
- BusB  out  DATA_W  registered read data, port B
- registers_array  out  DATA_W × REG_COUNT (unpacked array)  live, combinational view of every register

## Operation
- All 16 registers are general purpose and writable, including R0. There is no hardwired zero.
- **Write:** on a rising edge with EN=1 and EnW=1, register[RW] takes BusW. In every other case, no register changes.
- **Read:** on a rising edge with EN=1, BusA takes register[RA] and BusB takes register[RB]. With EN=0, BusA and BusB hold their values.
- **Same-edge write and read of one register:** read-before-write. BusA/BusB capture the old contents, and the new value appears on the next enabled read edge.
- **RA = RB:** both ports return the same value.
- **registers_array[i]:** continuously equals register[i]. It updates immediately after a write edge.
- **Reset (reset=0, asynchronous):**
  - all registers are 0;
  - BusA and BusB are 0;
  - registers_array is all 0.
- **Reset mid-operation:** reset overrides any write in flight. Release is synchronous to the first rising edge with reset=1.

## Timing
- Write latency: 1 edge. Data is visible on registers_array right after the edge and on BusA/BusB at the following enabled edge.
- Read latency: 1 edge from RA/RB to BusA/BusB.
- Back-to-back writes are allowed on every cycle.
- Any X on RA/RB/RW while EN=1 is a usage error. Outputs are then undefined until a valid read.

## Structure
- Shared package `register_file_pkg` holds DATA_W, REG_COUNT, ADDR_W and the register-word typedef.
- Storage is a single array with one write process and one read/output process.
- Sub-module `clock_generator` is simulation-only. It is not synthesizable and is used by benches, not instantiated in the RTL. Its behaviour:
  - output `clock`;
  - period 10 time units, 50% duty cycle;
  - starts low, first rising edge at t=5.

## Test plan
- **Reset:** assert reset=0 with random RA/RB/RW/BusW and EnW=1 -> all registers_array entries, BusA and BusB read 0. Releasing reset causes no spurious write.
- **Write then read:** write R1←16 and then R2←32, with EN=1, EnW=1, one edge each. Then RA=1, RB=2, EnW=0 -> after one edge, BusA=16 and BusB=32, and registers_array[1]=16, [2]=32.
- **Read-before-write:** with RA=1, RB=2, write R2←64 in the same edge -> BusB=32 at that edge and BusB=64 at the next, while BusA stays 16.
- **Write disabled:** RW=2, BusW=128, EnW=0 for several edges -> R2 stays 64 and BusB stays 64.
- **EN=0 freeze:** EnW=1, RW=3, BusW=0xDEADBEEF, and new RA/RB with EN=0 -> R3 unchanged (0), and BusA/BusB hold their previous values.
- **Full sweep:** write Ri←i·0x01010101 for i=0..15, then read all pairs (i, 15−i) -> every value matches. The sweep includes R0 and R15 at the address boundaries.

Source files
------------

// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_pkg
//  Description : Shared sizing constants and word typedefs for the Simple
//                RISC register file and the benches that drive it.
//                DATA_W    - register and bus width
//                REG_COUNT - number of general-purpose registers
//                ADDR_W    - register address width, log2(REG_COUNT)
//  Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 16;
    localparam int ADDR_W    = $clog2(REG_COUNT);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage : register_file_pkg
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 16 x 32-bit general-purpose register file with two
//                registered read ports and one synchronous write port,
//                all gated by a stage enable. R0 is an ordinary register.
//  Ports       :
//    clock           in   system clock, rising-edge active
//    reset           in   asynchronous active-low reset, clears all state
//    RA, RB          in   read addresses for ports A and B
//    RW              in   write address
//    EnW             in   write enable
//    BusW            in   write data
//    EN              in   stage enable, gates both reads and writes
//    BusA, BusB      out  registered read data
//    registers_array out  live combinational view of every register
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import register_file_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  addr_t RA,
    input  addr_t RB,
    input  addr_t RW,
    input  logic  EnW,
    input  word_t BusW,
    input  logic  EN,
    output word_t BusA,
    output word_t BusB,
    output word_t registers_array [REG_COUNT]
);

    word_t regs_q [REG_COUNT];
    word_t regs_d [REG_COUNT];
    word_t bus_a_q;
    word_t bus_a_d;
    word_t bus_b_q;
    word_t bus_b_d;

    // ------------------------------------------------------------------
    // Write process: only the addressed entry may change, and only when
    // both the stage and the write port are enabled.
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (EN && EnW) begin
            regs_d[RW] = BusW;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Read/output process: reads sample regs_q (the pre-edge contents),
    // which gives read-before-write when RA/RB match RW on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        bus_a_d = bus_a_q;
        bus_b_d = bus_b_q;
        if (EN) begin
            bus_a_d = regs_q[RA];
            bus_b_d = regs_q[RB];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_a_q <= '0;
            bus_b_q <= '0;
        end else begin
            bus_a_q <= bus_a_d;
            bus_b_q <= bus_b_d;
        end
    end

    assign BusA            = bus_a_q;
    assign BusB            = bus_b_q;
    assign registers_array = regs_q;

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file. A behavioural
//                array model tracks register contents and expected read
//                data; a compare process checks every output on each
//                falling edge, and directed steps pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;
    import register_file_pkg::*;

    localparam word_t c_pat = 32'h0101_0101;

    logic  clock = 1'b0;
    logic  reset;
    addr_t RA, RB, RW;
    logic  EnW, EN;
    word_t BusW;
    word_t BusA, BusB;
    word_t regs_view [REG_COUNT];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    word_t mdl      [REG_COUNT] = '{default: '0};
    word_t mdl_a    = '0;
    word_t mdl_b    = '0;

    register_file dut (
        .clock           (clock),
        .reset           (reset),
        .RA              (RA),
        .RB              (RB),
        .RW              (RW),
        .EnW             (EnW),
        .BusW            (BusW),
        .EN              (EN),
        .BusA            (BusA),
        .BusB            (BusB),
        .registers_array (regs_view)
    );

    // Period 10, starts low, first rising edge at t=5
    always #5 clock = ~clock;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: reads see contents before this edge's write.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) mdl[i] = '0;
            mdl_a = '0;
            mdl_b = '0;
        end else if (EN) begin
            mdl_a = mdl[RA];
            mdl_b = mdl[RB];
            if (EnW) mdl[RW] = BusW;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clock) begin
        if (check_en) begin
            check("BusA_model", BusA, mdl_a);
            check("BusB_model", BusB, mdl_b);
            for (int i = 0; i < REG_COUNT; i++) begin
                check($sformatf("reg%0d_model", i), regs_view[i], mdl[i]);
            end
        end
    end

    task automatic cyc(input logic en, input logic enw, input addr_t rw,
                       input word_t busw, input addr_t ra, input addr_t rb);
        @(negedge clock);
        EN   = en;
        EnW  = enw;
        RW   = rw;
        BusW = busw;
        RA   = ra;
        RB   = rb;
        @(posedge clock);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // Reset with random inputs and writes requested
        reset = 1'b0;
        EN    = 1'b1;
        EnW   = 1'b1;
        RA    = addr_t'($urandom_range(0, REG_COUNT-1));
        RB    = addr_t'($urandom_range(0, REG_COUNT-1));
        RW    = addr_t'($urandom_range(0, REG_COUNT-1));
        BusW  = word_t'($urandom);
        @(posedge clock);
        check_en = 1'b1;
        @(posedge clock);
        #1;
        check("reset_BusA", BusA, 32'h0);
        check("reset_BusB", BusB, 32'h0);
        for (int i = 0; i < REG_COUNT; i++)
            check($sformatf("reset_reg%0d", i), regs_view[i], 32'h0);

        // Release reset with no write requested
        @(negedge clock);
        EnW   = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < REG_COUNT; i++)
            check($sformatf("release_reg%0d", i), regs_view[i], 32'h0);

        // Write then read
        cyc(1, 1, 4'd1, 32'd16, 4'd0, 4'd0);
        check("wr_R1_view", regs_view[1], 32'd16);
        cyc(1, 1, 4'd2, 32'd32, 4'd0, 4'd0);
        cyc(1, 0, 4'd0, 32'd0, 4'd1, 4'd2);
        check("rd_BusA_16", BusA, 32'd16);
        check("rd_BusB_32", BusB, 32'd32);
        check("rd_R2_view", regs_view[2], 32'd32);

        // Read-before-write on R2
        cyc(1, 1, 4'd2, 32'd64, 4'd1, 4'd2);
        check("rbw_BusB_old", BusB, 32'd32);
        check("rbw_R2_new", regs_view[2], 32'd64);
        cyc(1, 0, 4'd0, 32'd0, 4'd1, 4'd2);
        check("rbw_BusB_new", BusB, 32'd64);
        check("rbw_BusA_16", BusA, 32'd16);

        // Write disabled
        repeat (3) cyc(1, 0, 4'd2, 32'd128, 4'd1, 4'd2);
        check("wdis_R2", regs_view[2], 32'd64);
        check("wdis_BusB", BusB, 32'd64);

        // Stage disabled: nothing moves
        repeat (2) cyc(0, 1, 4'd3, 32'hDEAD_BEEF, 4'd5, 4'd6);
        check("freeze_R3", regs_view[3], 32'h0);
        check("freeze_BusA", BusA, 32'd16);
        check("freeze_BusB", BusB, 32'd64);

        // Full sweep including R0 and R15
        for (int i = 0; i < REG_COUNT; i++)
            cyc(1, 1, addr_t'(i), word_t'(i) * c_pat, 4'd0, 4'd0);
        check("sweep_R0", regs_view[0], 32'h0000_0000);
        check("sweep_R15", regs_view[15], 32'h0F0F_0F0F);
        for (int i = 0; i < REG_COUNT; i++) begin
            cyc(1, 0, 4'd0, 32'd0, addr_t'(i), addr_t'(15 - i));
            check($sformatf("sweep_BusA_%0d", i), BusA, word_t'(i) * c_pat);
            check($sformatf("sweep_BusB_%0d", i), BusB, word_t'(15 - i) * c_pat);
        end

        // RA = RB
        cyc(1, 0, 4'd0, 32'd0, 4'd7, 4'd7);
        check("same_BusA", BusA, 32'h0707_0707);
        check("same_BusB", BusB, 32'h0707_0707);

        // Reset mid-operation overrides a pending write
        @(negedge clock);
        EN   = 1'b1;
        EnW  = 1'b1;
        RW   = 4'd9;
        BusW = 32'hCAFE_F00D;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_R5_async", regs_view[5], 32'h0);
        check("midrst_BusA_async", BusA, 32'h0);
        @(posedge clock);
        #1;
        check("midrst_R9", regs_view[9], 32'h0);
        @(negedge clock);
        EnW   = 1'b0;
        reset = 1'b1;
        cyc(1, 0, 4'd0, 32'd0, 4'd9, 4'd15);
        check("post_rst_BusA", BusA, 32'h0);
        check("post_rst_BusB", BusB, 32'h0);

        @(negedge clock);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
